// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
package otter_lsu_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  localparam logic [1:0] SIZE_B   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_W   = 2'd2;
  localparam logic [1:0] SIZE_ILL = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WAIT  = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    RESP  = 3'd6
  } lsu_state_e;

  // Bytes never straddle a word; halves only straddle from offset 3.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      SIZE_H:  mis = (off == 2'd3);
      SIZE_W:  mis = (off != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/otter_lsu_align.sv
// Combinational load extraction and store merge over a {hi,lo} word pair.
module otter_lsu_align
  import otter_lsu_pkg::*;
(
  input  logic [63:0] pair_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [63:0] merge_o
);

  logic [31:0] shifted_s;
  logic [7:0]  bmask_s;
  logic [63:0] bitmask_s;
  logic [63:0] wshift_s;

  // Right-shift the pair by the byte offset, then truncate and extend.
  always_comb begin
    case (off_i)
      2'd0:    shifted_s = pair_i[31:0];
      2'd1:    shifted_s = pair_i[39:8];
      2'd2:    shifted_s = pair_i[47:16];
      2'd3:    shifted_s = pair_i[55:24];
      default: shifted_s = 32'h0;
    endcase
    // sign_i set means unsigned (lbu/lhu).
    case (size_i)
      SIZE_B:  load_o = sign_i ? {24'h0, shifted_s[7:0]}  : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SIZE_H:  load_o = sign_i ? {16'h0, shifted_s[15:0]} : {{16{shifted_s[15]}}, shifted_s[15:0]};
      SIZE_W:  load_o = shifted_s;
      default: load_o = 32'h0;
    endcase
  end

  // Byte-mask the store data into the old pair.
  always_comb begin
    case (size_i)
      SIZE_B:  bmask_s = 8'h01;
      SIZE_H:  bmask_s = 8'h03;
      SIZE_W:  bmask_s = 8'h0F;
      default: bmask_s = 8'h00;
    endcase
    bmask_s = bmask_s << off_i;
    for (int i = 0; i < 8; i++) begin
      bitmask_s[8*i +: 8] = {8{bmask_s[i]}};
    end
    wshift_s = {32'h0, wdata_i} << {off_i, 3'b000};
    merge_o  = (pair_i & ~bitmask_s) | (wshift_s & bitmask_s);
  end

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit driving data port 2 of the dual-port memory.
// Define OTTER_LSU_MISALIGN_EN to split misaligned accesses; otherwise they are rejected.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_ADDR,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

`ifdef OTTER_LSU_MISALIGN_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d, we_q, we_d, mis_q, mis_d;

  logic        ready_q, ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;
  logic        mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic [1:0]  mem_size_q, mem_size_d;

  logic [31:0] req_lo_s, cur_lo_s, cur_hi_s, load_s;
  logic        req_mis_s, req_ill_s;
  logic [63:0] pair_s, merge_s;

  assign req_lo_s  = {REQ_ADDR[31:2], 2'b00};
  assign req_mis_s = is_misaligned(REQ_ADDR[1:0], REQ_SIZE);
  // A split access must not touch IO space nor wrap past the top of memory.
  assign req_ill_s = (REQ_SIZE == SIZE_ILL) ||
                     (req_mis_s && (!MIS_EN || (req_lo_s >= IO_BASE) || (req_lo_s == 32'hFFFF_FFFC)));
  assign cur_lo_s  = {addr_q[31:2], 2'b00};
  assign cur_hi_s  = cur_lo_s + 32'd4;

  // In WAIT the second word is still on MEM_DOUT2; later states use the captured pair.
  always_comb begin
    if (state_q == WAIT) begin
      if (mis_q) begin
        pair_s = {MEM_DOUT2, lo_q};
      end else begin
        pair_s = {32'h0, MEM_DOUT2};
      end
    end else begin
      pair_s = {hi_q, lo_q};
    end
  end

  otter_lsu_align u_align (
    .pair_i  (pair_s),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .wdata_i (wdata_q),
    .load_o  (load_s),
    .merge_o (merge_s)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    sign_d      = sign_q;
    we_d        = we_q;
    mis_d       = mis_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = 32'h0;
    mem_din_d   = 32'h0;
    mem_size_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (REQ_VALID && ready_q) begin
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          size_d  = REQ_SIZE;
          sign_d  = REQ_SIGN;
          we_d    = REQ_WE;
          mis_d   = req_mis_s;
          if (req_ill_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (REQ_WE && !req_mis_s) begin
            state_d     = WR_LO;
            mem_write_d = 1'b1;
            mem_addr_d  = REQ_ADDR;
            mem_size_d  = REQ_SIZE;
            mem_din_d   = REQ_WDATA;
          end else begin
            state_d    = RD_LO;
            mem_read_d = 1'b1;
            mem_addr_d = req_lo_s;
            mem_size_d = SIZE_W;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_LO: begin
        if (mis_q) begin
          state_d    = RD_HI;
          mem_read_d = 1'b1;
          mem_addr_d = cur_hi_s;
          mem_size_d = SIZE_W;
        end else begin
          state_d = WAIT;
        end
      end
      RD_HI: begin
        lo_d    = MEM_DOUT2;
        state_d = WAIT;
      end
      WAIT: begin
        if (mis_q) begin
          hi_d = MEM_DOUT2;
        end else begin
          lo_d = MEM_DOUT2;
        end
        // Only misaligned stores come through WAIT.
        if (we_q) begin
          state_d     = WR_LO;
          mem_write_d = 1'b1;
          mem_addr_d  = cur_lo_s;
          mem_size_d  = SIZE_W;
          mem_din_d   = merge_s[31:0];
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_s;
        end
      end
      WR_LO: begin
        if (mis_q) begin
          state_d     = WR_HI;
          mem_write_d = 1'b1;
          mem_addr_d  = cur_hi_s;
          mem_size_d  = SIZE_W;
          mem_din_d   = merge_s[63:32];
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end
      end
      WR_HI: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, request capture and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      lo_q        <= 32'h0;
      hi_q        <= 32'h0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_din_q   <= 32'h0;
      mem_size_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_size_q  <= mem_size_d;
    end
  end

  assign REQ_READY  = ready_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ERR    = rsp_err_q;
  assign RSP_RDATA  = rsp_rdata_q;
  assign MEM_ADDR2  = mem_addr_q;
  assign MEM_DIN2   = mem_din_q;
  assign MEM_WRITE2 = mem_write_q;
  assign MEM_READ2  = mem_read_q;
  assign MEM_SIZE   = mem_size_q;
  // Every access is a raw word or an in-place store, so memory-side extension is never wanted.
  assign MEM_SIGN   = 1'b0;

endmodule

// File: tb/tb_otter_lsu.sv
// Directed scoreboard bench for otter_lsu with a byte-addressed port-2 memory model.
module tb_otter_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_SIGN;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
  logic [1:0]  MEM_SIZE;

  otter_lsu dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_WE(REQ_WE),
    .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } rsp_t;

  rsp_t        sb_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rd_log[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0, acc_cyc = 0, base_rd = 0, base_wr = 0, wr_cnt = 0, overlap = 0;
  logic        preload = 1'b0;
  logic [7:0]  mem [0:511];
  logic [31:0] dout_r = 32'h0;

  assign MEM_DOUT2 = dout_r;

  // Memory: preload 0x100..0x107 with 11 22 .. 88, sized in-place writes, one-cycle read latency.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[9'h100 + 9'(i)] <= 8'((i + 1) * 17);
    end else if (MEM_WRITE2) begin
      mem[MEM_ADDR2[8:0]] <= MEM_DIN2[7:0];
      if (MEM_SIZE != 2'd0) mem[MEM_ADDR2[8:0] + 9'd1] <= MEM_DIN2[15:8];
      if (MEM_SIZE == 2'd2) begin
        mem[MEM_ADDR2[8:0] + 9'd2] <= MEM_DIN2[23:16];
        mem[MEM_ADDR2[8:0] + 9'd3] <= MEM_DIN2[31:24];
      end
    end
    if (MEM_READ2)
      dout_r <= {mem[MEM_ADDR2[8:0] + 9'd3], mem[MEM_ADDR2[8:0] + 9'd2],
                 mem[MEM_ADDR2[8:0] + 9'd1], mem[MEM_ADDR2[8:0]]};
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: log memory traffic and capture each response with its latency and access counts.
  always @(negedge CLK) begin
    if (MEM_READ2 && MEM_WRITE2) overlap <= overlap + 1;
    if (MEM_READ2) rd_log.push_back(MEM_ADDR2);
    if (MEM_WRITE2) wr_cnt <= wr_cnt + 1;
    if (RSP_VALID)
      rsp_q.push_back('{RSP_RDATA, RSP_ERR, cyc - acc_cyc + 1, rd_log.size() - base_rd, wr_cnt - base_wr});
  end

  function automatic logic [31:0] word_at(input logic [8:0] a);
    return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge CLK) preload = 1'b1;
    @(negedge CLK) preload = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg);
    @(negedge CLK);
    for (int k = 0; k < 20 && !REQ_READY; k++) @(negedge CLK);
    REQ_ADDR = a; REQ_WE = we; REQ_WDATA = wd; REQ_SIZE = sz; REQ_SIGN = sg; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    acc_cyc   = cyc;
    base_rd   = rd_log.size();
    base_wr   = wr_cnt;
    REQ_VALID = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input logic [31:0] e_rd_data,
                        input logic e_err, input int e_lat, input int e_rd, input int e_wr);
    rsp_t e, r;
    sb_q.push_back('{e_rd_data, e_err, e_lat, e_rd, e_wr});
    issue(a, we, wd, sz, sg);
    for (int k = 0; k < 12 && rsp_q.size() == 0; k++) @(negedge CLK);
    e = sb_q.pop_front();
    chk({tag, " response seen"}, 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk({tag, " rdata"}, r.rdata, e.rdata);
      chk({tag, " err"}, 32'(r.err), 32'(e.err));
      chk({tag, " latency"}, r.lat, e.lat);
      chk({tag, " reads"}, r.rd, e.rd);
      chk({tag, " writes"}, r.wr, e.wr);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " RSP_VALID"}, 32'(RSP_VALID), 32'd0);
    chk({tag, " RSP_ERR"}, 32'(RSP_ERR), 32'd0);
    chk({tag, " MEM_READ2"}, 32'(MEM_READ2), 32'd0);
    chk({tag, " MEM_WRITE2"}, 32'(MEM_WRITE2), 32'd0);
    chk({tag, " RSP_RDATA"}, RSP_RDATA, 32'd0);
    chk({tag, " MEM_ADDR2"}, MEM_ADDR2, 32'd0);
    chk({tag, " REQ_READY"}, 32'(REQ_READY), 32'd1);
  endtask

  initial begin
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_ADDR = 32'h0; REQ_WE = 1'b0;
    REQ_WDATA = 32'h0; REQ_SIZE = 2'd0; REQ_SIGN = 1'b0;
    preload = 1'b1;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    preload = 1'b0;
    RST_N   = 1'b1;

    do_req("lw 0x100", 32'h100, 1'b0, 32'h0, 2'd2, 1'b0, 32'h4433_2211, 1'b0, 3, 1, 0);
    do_req("lb 0x107", 32'h107, 1'b0, 32'h0, 2'd0, 1'b0, 32'hFFFF_FF88, 1'b0, 3, 1, 0);
    do_req("lbu 0x107", 32'h107, 1'b0, 32'h0, 2'd0, 1'b1, 32'h0000_0088, 1'b0, 3, 1, 0);
    do_req("lh 0x106", 32'h106, 1'b0, 32'h0, 2'd1, 1'b0, 32'hFFFF_8877, 1'b0, 3, 1, 0);
    do_req("lhu 0x104", 32'h104, 1'b0, 32'h0, 2'd1, 1'b1, 32'h0000_6655, 1'b0, 3, 1, 0);
    do_req("sb 0x105", 32'h105, 1'b1, 32'h0000_005A, 2'd0, 1'b0, 32'h0, 1'b0, 2, 0, 1);
    chk("sb 0x105 mem", word_at(9'h104), 32'h8877_5A55);
    do_preload();
    do_req("size3", 32'h100, 1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    do_req("lh io", 32'h1100_0003, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1, 1, 0, 0);

`ifdef OTTER_LSU_MISALIGN_EN
    do_req("lw 0x102", 32'h102, 1'b0, 32'h0, 2'd2, 1'b0, 32'h6655_4433, 1'b0, 4, 2, 0);
    chk("lw 0x102 rd0 addr", rd_log[base_rd], 32'h100);
    chk("lw 0x102 rd1 addr", rd_log[base_rd + 1], 32'h104);
    do_req("lh 0x103", 32'h103, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0000_5544, 1'b0, 4, 2, 0);
    do_req("lw wrap", 32'hFFFF_FFFE, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sw 0x101", 32'h101, 1'b1, 32'hAABB_CCDD, 2'd2, 1'b0, 32'h0, 1'b0, 6, 2, 2);
    chk("sw 0x101 lo", word_at(9'h100), 32'hBBCC_DD11);
    chk("sw 0x101 hi", word_at(9'h104), 32'h8877_66AA);

    do_preload();
    issue(32'h101, 1'b1, 32'hAABB_CCDD, 2'd2, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    chk("wr_hi MEM_WRITE2", 32'(MEM_WRITE2), 32'd1);
    chk("wr_hi MEM_ADDR2", MEM_ADDR2, 32'h104);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("reset in WR_HI");
    @(negedge CLK);
    chk("reset WR_HI lo", word_at(9'h100), 32'hBBCC_DD11);
    chk("reset WR_HI hi", word_at(9'h104), 32'h8877_6655);
`else
    do_req("lw 0x102 off", 32'h102, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sw 0x101 off", 32'h101, 1'b1, 32'hAABB_CCDD, 2'd2, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    chk("sw 0x101 off mem", word_at(9'h100), 32'h4433_2211);

    issue(32'h100, 1'b0, 32'h0, 2'd2, 1'b0);
    chk("rd_lo MEM_READ2", 32'(MEM_READ2), 32'd1);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("reset in RD_LO");
    @(negedge CLK);
`endif
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("no stray response", 32'(rsp_q.size()), 32'd0);
    do_req("lw after reset", 32'h104, 1'b0, 32'h0, 2'd2, 1'b0, 32'h8877_6655, 1'b0, 3, 1, 0);
    chk("rd/wr overlap", overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
